// File: rtl/alu_serial_addsub_if.sv
// ----------------------------------------------------------------------------
// alu_serial_addsub_if
// Handshake and data bundle for the serial 32-bit adder/subtractor.
//   start    : request, sampled when the unit is not busy
//   sub      : 1 = a - b, 0 = a + b (captured with start)
//   a, b     : operands (captured with start)
//   busy     : computation in progress
//   done     : one-cycle pulse, result and flags freshly updated
//   result   : sum or difference
//   negative : result[31]
//   zero     : result == 0
//   overflow : signed overflow
//   carry    : carry out of bit 31 (for sub, 1 = no borrow)
//   ovf_trap : (only with ALU_OVF_TRAP_EN) pulse with done on signed overflow
// Modports: master drives the request side, slave is the arithmetic unit.
// ----------------------------------------------------------------------------
interface alu_serial_addsub_if;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry;
`ifdef ALU_OVF_TRAP_EN
    logic        ovf_trap;
`endif

`ifdef ALU_OVF_TRAP_EN
    modport master (
        output start, sub, a, b,
        input  busy, done, result, negative, zero, overflow, carry, ovf_trap
    );
    modport slave (
        input  start, sub, a, b,
        output busy, done, result, negative, zero, overflow, carry, ovf_trap
    );
`else
    modport master (
        output start, sub, a, b,
        input  busy, done, result, negative, zero, overflow, carry
    );
    modport slave (
        input  start, sub, a, b,
        output busy, done, result, negative, zero, overflow, carry
    );
`endif
endinterface

// File: rtl/alu_serial_addsub.sv
// ----------------------------------------------------------------------------
// alu_serial_addsub
// Multi-cycle 32-bit adder/subtractor processing SLICE bits per clock.
// Latency from the start edge to done is N = 32/SLICE cycles; a start seen
// in the DONE cycle chains the next operation (one result per N+1 cycles).
//
// Ports:
//   clk    : rising-edge system clock
//   reset  : synchronous, active-high
//   bus    : alu_serial_addsub_if.slave (start/sub/a/b in,
//            busy/done/result/negative/zero/overflow/carry out)
//
// Optional feature macro: ALU_OVF_TRAP_EN adds bus.ovf_trap, a pulse
// coincident with done whenever the result overflowed.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one slice per edge, counter selects the slice
// DONE  | one cycle, done = 1; start here chains a new operation
// ----------------------------------------------------------------------------
module alu_serial_addsub #(
    parameter int SLICE = 8,
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_serial_addsub_if.slave   bus
);
    localparam int N  = 32 / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH != 32) begin : g_bad_width
        $error("alu_serial_addsub: WIDTH must be 32");
    end
    if (SLICE != 1 && SLICE != 2 && SLICE != 4 && SLICE != 8 &&
        SLICE != 16 && SLICE != 32) begin : g_bad_slice
        $error("alu_serial_addsub: SLICE must be 1, 2, 4, 8, 16 or 32");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [31:0]     op_a;
    logic [31:0]     op_b;       // b, or ~b for subtraction
    logic            cy;         // carry between slices
    logic [31:0]     res;
    logic            neg_q;
    logic            zero_q;
    logic            ovf_q;
    logic            carry_q;

    logic            accept;
    logic            last_slice;
    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_sum;
    logic            sl_cout;
    logic            c_into_msb;
    logic [31:0]     res_merged;

    // Datapath for the current slice
    always_comb begin
        accept     = bus.start && (state != S_RUN);
        last_slice = (state == S_RUN) && (cnt == LAST);
        sl_a       = op_a[cnt*SLICE +: SLICE];
        sl_b       = op_b[cnt*SLICE +: SLICE];
        {sl_cout, sl_sum} = {1'b0, sl_a} + {1'b0, sl_b} + {{SLICE{1'b0}}, cy};
        // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out
        // of the top bit of the final slice.
        c_into_msb = sl_a[SLICE-1] ^ sl_b[SLICE-1] ^ sl_sum[SLICE-1];
        res_merged = res;
        res_merged[cnt*SLICE +: SLICE] = sl_sum;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_RUN;
            S_RUN:   if (cnt == LAST) state_next = S_DONE;
            S_DONE:  state_next = accept ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            cy      <= 1'b0;
            res     <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
        end else if (accept) begin
            op_a <= bus.a;
            op_b <= bus.sub ? ~bus.b : bus.b;
            cy   <= bus.sub;   // +1 completes the two's complement of b
            cnt  <= '0;
        end else if (state == S_RUN) begin
            res <= res_merged;
            cy  <= sl_cout;
            cnt <= cnt + 1'b1;
            if (last_slice) begin
                carry_q <= sl_cout;
                ovf_q   <= c_into_msb ^ sl_cout;
                neg_q   <= sl_sum[SLICE-1];
                zero_q  <= (res_merged == 32'd0);
            end
        end
    end

`ifdef ALU_OVF_TRAP_EN
    logic trap_q;
    always_ff @(posedge clk) begin
        if (reset) trap_q <= 1'b0;
        else       trap_q <= last_slice && (c_into_msb ^ sl_cout);
    end
    assign bus.ovf_trap = trap_q;
`endif

    assign bus.busy     = (state == S_RUN);
    assign bus.done     = (state == S_DONE);
    assign bus.result   = res;
    assign bus.negative = neg_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
    assign bus.carry    = carry_q;

endmodule

// File: tb/tb_alu_serial_addsub.sv
module tb_alu_serial_addsub;
    parameter int SLICE = 8;
    localparam int N = 32 / SLICE;

    typedef struct {
        logic [31:0] r;
        logic        n;
        logic        z;
        logic        v;
        logic        c;
        int          k;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    bit   mon_en;
    exp_t sb[$];

    alu_serial_addsub_if bus ();

    alu_serial_addsub #(.SLICE(SLICE), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain integer arithmetic on the operands
    function automatic exp_t model(input logic s, input logic [31:0] a,
                                   input logic [31:0] b, input int k);
        exp_t e;
        longint sa = $signed(a);
        longint sbv = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint ex = s ? (sa - sbv) : (sa + sbv);
        e.r = s ? (a - b) : (a + b);
        e.c = s ? (ua >= ub) : ((ua + ub) > 64'hFFFF_FFFF);
        e.v = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
        e.n = e.r[31];
        e.z = (e.r == 32'd0);
        e.k = k;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One stimulus cycle; expectation is queued only when the DUT will take it
    task automatic step(input logic st, input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = st;
        bus.sub   = s;
        bus.a     = a;
        bus.b     = b;
        if (st && !bus.busy && !reset) sb.push_back(model(s, a, b, cyc + 1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4 * N + 20; i++) begin
            if (sb.size() == 0 && !bus.busy) break;
            step(1'b0, 1'b0, $urandom(), $urandom());
        end
    endtask

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        step(1'b1, s, a, b);
        wait_idle();
    endtask

    // Monitor: compares every done against the oldest expectation
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_done: got done=1 want no done (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("latency",  32'(cyc - e.k), 32'(N));
                        chk("result",   bus.result, e.r);
                        chk("negative", {31'd0, bus.negative}, {31'd0, e.n});
                        chk("zero",     {31'd0, bus.zero},     {31'd0, e.z});
                        chk("overflow", {31'd0, bus.overflow}, {31'd0, e.v});
                        chk("carry",    {31'd0, bus.carry},    {31'd0, e.c});
`ifdef ALU_OVF_TRAP_EN
                        chk("ovf_trap", {31'd0, bus.ovf_trap}, {31'd0, e.v});
`endif
                    end
                end else begin
`ifdef ALU_OVF_TRAP_EN
                    if (bus.ovf_trap) chk("ovf_trap_idle", 32'd1, 32'd0);
`endif
                    if (sb.size() != 0 && cyc >= sb[0].k + N) begin
                        total++;
                        bad++;
                        $display("FAIL missing_done: got done=0 want done=1 (cycle %0d)", cyc);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int kk;
        total = 0;
        bad   = 0;
        mon_en = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",     {31'd0, bus.busy},     32'd0);
        chk("rst_done",     {31'd0, bus.done},     32'd0);
        chk("rst_result",   bus.result,            32'd0);
        chk("rst_zero",     {31'd0, bus.zero},     32'd1);
        chk("rst_carry",    {31'd0, bus.carry},    32'd0);
        chk("rst_negative", {31'd0, bus.negative}, 32'd0);
        chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Directed cases
        issue(1'b1, 32'd5, 32'd3);
        issue(1'b1, 32'd3, 32'd5);
        issue(1'b1, 32'h8000_0000, 32'h0000_0001);
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001);

        // start held high with fresh operands every cycle: only the
        // operands present at IDLE/DONE edges may be taken
        for (int i = 0; i < 3 * (N + 1) + 1; i++)
            step(1'b1, 1'($urandom_range(0, 1)), pick(), pick());
        wait_idle();

        // Reset during RUN: abort at the 2nd RUN edge (only edge when N = 1)
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = 1'b1;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'h0000_1111;
        kk = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("abort_busy_run", {31'd0, bus.busy}, 32'd1);
        if (N == 1) reset = 1'b1;
        else begin
            @(negedge clk);
            reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        chk("abort_start_edge", 32'(cyc - kk), (N == 1) ? 32'd1 : 32'd2);
        chk("abort_busy",   {31'd0, bus.busy},  32'd0);
        chk("abort_done",   {31'd0, bus.done},  32'd0);
        chk("abort_result", bus.result,         32'd0);
        chk("abort_zero",   {31'd0, bus.zero},  32'd1);
        chk("abort_carry",  {31'd0, bus.carry}, 32'd0);
        repeat (N + 3) step(1'b0, 1'b0, '0, '0);
        issue(1'b0, 32'h0000_00FF, 32'h0000_0001);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), pick(), pick());
        wait_idle();
        repeat (2) step(1'b0, 1'b0, '0, '0);
        chk("queue_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_serial_addsub.md
Name: alu_serial_addsub

Overview:
- Multi-cycle 32-bit adder/subtractor that computes SLICE bits per clock.
- Sits directly upstream of the ALU compare stages; its negative/carry/overflow/zero flags feed them.
- The unsigned compare consumes the carry output directly: less-than = ~carry.
- Trades latency for a narrow carry chain; a start/busy/done handshake sequences it.

Parameters:
SLICE, 8, bits processed per cycle; legal values 1, 2, 4, 8, 16, 32; must divide 32.
WIDTH, 32, operand width; fixed at 32, any other value is a compile-time error.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when the unit is not busy.
sub  input  1  1 = a - b, 0 = a + b; captured with start.
a  input  32  operand A; captured with start.
b  input  32  operand B; captured with start.
busy  output  1  high while a computation is in progress.
done  output  1  one-cycle pulse: result and flags are valid and newly updated.
result  output  32  sum or difference.
negative  output  1  result[31].
zero  output  1  1 when result == 0.
overflow  output  1  signed overflow.
carry  output  1  carry out of bit 31; for sub, 1 = no borrow (a >= b unsigned).

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on reset. All state updates on the rising edge of clk.
- Reset: state = IDLE, slice counter = 0, busy = 0, done = 0, result = 0, negative = 0, zero = 1, overflow = 0, carry = 0.
- Reset mid-operation aborts the computation; done is not pulsed.
- N = 32/SLICE.
- IDLE, or the DONE cycle, with start = 1 at edge k:
  - latch a, sub, and b (or ~b when sub = 1);
  - carry-in register = sub;
  - counter = 0; state -> RUN; busy = 1.
- RUN, each edge:
  - add slice [counter*SLICE +: SLICE] of latched a and b' with the carry register;
  - write that slice of result; update the carry register; increment counter.
- Final slice (counter = N-1):
  - compute carry = carry out of bit 31;
  - overflow = carry into bit 31 XOR carry out of bit 31;
  - negative = bit 31 of result;
  - zero = all 32 result bits 0, including the final slice;
  - state -> DONE; busy = 0; done = 1.
- Latency: start sampled at edge k gives done high in the cycle after edge k+N. Example: SLICE = 8 gives done after edge k+4.
- DONE (one cycle): done = 1. At the next edge state -> IDLE and done -> 0, unless start = 1, which begins a new operation (back-to-back throughput, one result per N+1 cycles).
- start while RUN is ignored; latched operands are unaffected.
- result and flags are not glitch-free during RUN:
  - partial result slices update in place;
  - flags hold their previous values until the final edge;
  - consumers sample only on done.
- Between operations, outputs hold their last values until the next final-slice edge.
- Addition: carry = unsigned carry out, overflow = signed overflow. Wrap-around is modulo 2^32.
- Operands a/b may change freely after the start edge.

Optional Feature:
ALU_OVF_TRAP_EN:
- Defined: adds output port ovf_trap (1 bit), reset 0.
- ovf_trap is a one-cycle pulse coincident with done when overflow = 1 on that result, for add or sub.
- Not defined: the port does not exist and there is no extra logic. All other behaviour is identical.

Test Plan:
- Subtract, no borrow: sub = 1, a = 5, b = 3, start pulse. Expect:
  - done exactly N cycles after start;
  - result = 0x00000002, carry = 1, negative = 0, zero = 0, overflow = 0.
- Subtract with borrow: sub = 1, a = 3, b = 5. Expect:
  - result = 0xFFFFFFFE, carry = 0 (unsigned less-than true), negative = 1, overflow = 0.
- Signed overflow: sub = 1, a = 0x80000000, b = 0x00000001. Expect:
  - result = 0x7FFFFFFF, overflow = 1, negative = 0, carry = 1;
  - with ALU_OVF_TRAP_EN, ovf_trap pulses with done.
- Add wrap: sub = 0, a = 0xFFFFFFFF, b = 0x00000001. Expect:
  - result = 0x00000000, carry = 1, zero = 1, overflow = 0.
- Handshake:
  - start held high through RUN with new operands: second set ignored until DONE;
  - start in the DONE cycle: a second op begins immediately, and its done comes N+1 cycles after the first done.
  - Repeat for SLICE = 1 and SLICE = 32 (latency 32 and 1 cycles).
- Reset mid-operation: assert reset at the 2nd RUN edge. Expect:
  - next cycle busy = 0, done = 0, result = 0, zero = 1, carry = 0;
  - no done pulse afterward;
  - a new start completes normally.
